// File: rtl/gray_ptr_sync.sv
// Brings a Gray-coded FIFO pointer into the local clock domain through a
// flop-only synchroniser, then derives a registered binary pointer, an advance
// pulse/count and a sticky flag for illegal multi-bit Gray steps.
module gray_ptr_sync #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int CHECK_EN      = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [ADDRESS_WIDTH:0] G_ptr,
  input  logic                   Err_Clr,
  output logic [ADDRESS_WIDTH:0] Sync_Gptr,
  output logic [ADDRESS_WIDTH:0] Sync_Bptr,
  output logic                   Ptr_Adv,
  output logic [ADDRESS_WIDTH:0] Adv_Cnt,
  output logic                   Gray_Err
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] bptr_q, bptr_d;
  logic [PW-1:0] prev_bptr_q, prev_bptr_d;
  logic [PW-1:0] prev_gray_q, prev_gray_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          adv_q, adv_d;
  logic          err_q, err_d;

  logic [PW-1:0] sync_last;
  logic [PW-1:0] bin_new;
  logic [PW-1:0] gdiff;
  logic          changed;
  logic          multi_bit;

  always_comb begin
    sync_d[0] = G_ptr;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_last = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits at or above i.
    bin_new = '0;
    for (int i = 0; i < PW; i++) begin
      bin_new[i] = ^(sync_last >> i);
    end

    changed     = (bin_new != prev_bptr_q);
    bptr_d      = bin_new;
    prev_bptr_d = bin_new;
    prev_gray_d = sync_last;
    adv_d       = changed;
    cnt_d       = changed ? (bin_new - prev_bptr_q) : cnt_q;

    // More than one bit set in the Gray delta means a non-adjacent step.
    gdiff     = sync_last ^ prev_gray_q;
    multi_bit = |(gdiff & (gdiff - ONE));
    if (CHECK_EN != 0) begin
      err_d = (changed & multi_bit) | (err_q & ~Err_Clr);
    end else begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      bptr_q      <= '0;
      prev_bptr_q <= '0;
      prev_gray_q <= '0;
      cnt_q       <= '0;
      adv_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      bptr_q      <= bptr_d;
      prev_bptr_q <= prev_bptr_d;
      prev_gray_q <= prev_gray_d;
      cnt_q       <= cnt_d;
      adv_q       <= adv_d;
      err_q       <= err_d;
    end
  end

  assign Sync_Gptr = sync_q[SYNC_STAGES-1];
  assign Sync_Bptr = bptr_q;
  assign Ptr_Adv   = adv_q;
  assign Adv_Cnt   = cnt_q;
  assign Gray_Err  = err_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: two instances (2 and 4 synchroniser stages) share
// one stimulus stream and are checked every cycle against an edge-history model.
module tb_gray_ptr_sync;

  localparam int MAXE = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] g;
  logic       clr;

  logic [4:0] sg2, bp2, cnt2, sg4, bp4, cnt4;
  logic       adv2, err2, adv4, err4;

  always #5 clk = ~clk;

  gray_ptr_sync #(.ADDRESS_WIDTH(4), .SYNC_STAGES(2), .CHECK_EN(1)) u_dut2 (
    .CLK(clk), .RST(rst_n), .G_ptr(g), .Err_Clr(clr),
    .Sync_Gptr(sg2), .Sync_Bptr(bp2), .Ptr_Adv(adv2), .Adv_Cnt(cnt2), .Gray_Err(err2)
  );

  gray_ptr_sync #(.ADDRESS_WIDTH(4), .SYNC_STAGES(4), .CHECK_EN(1)) u_dut4 (
    .CLK(clk), .RST(rst_n), .G_ptr(g), .Err_Clr(clr),
    .Sync_Gptr(sg4), .Sync_Bptr(bp4), .Ptr_Adv(adv4), .Adv_Cnt(cnt4), .Gray_Err(err4)
  );

  int checks   = 0;
  int failures = 0;
  int ed       = 0;
  int last_rst = 0;

  // Model history, indexed by edge number; index 0 is the all-zero start.
  logic [4:0] hin   [0:MAXE-1];
  logic [4:0] m_sg  [0:1][0:MAXE-1];
  logic [4:0] m_bp  [0:1][0:MAXE-1];
  logic [4:0] m_cnt [0:1][0:MAXE-1];
  logic       m_adv [0:1][0:MAXE-1];
  logic       m_err [0:1][0:MAXE-1];

  function automatic logic [4:0] g2b(input logic [4:0] gv);
    logic [4:0] b;
    for (int i = 0; i < 5; i++) b[i] = ^(gv >> i);
    return b;
  endfunction

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, ed, act, exp);
    end
  endtask

  task automatic model_update();
    int s, src;
    logic [4:0] prev_sg, pp, nb;
    ed++;
    if (ed >= MAXE) begin
      $display("FAIL edge_budget edge=%0d got=%0d expected=<%0d", ed, ed, MAXE);
      $fatal(1, "edge budget exceeded");
    end
    hin[ed] = g;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_sg[d][ed] = '0; m_bp[d][ed] = '0; m_cnt[d][ed] = '0;
        m_adv[d][ed] = 1'b0; m_err[d][ed] = 1'b0;
      end else begin
        s   = (d == 0) ? 2 : 4;
        src = ed - s + 1;
        m_sg[d][ed]  = (src > last_rst && src >= 1) ? hin[src] : 5'd0;
        prev_sg      = m_sg[d][ed-1];
        pp           = (ed >= 2) ? m_sg[d][ed-2] : 5'd0;
        nb           = g2b(prev_sg);
        m_bp[d][ed]  = nb;
        m_adv[d][ed] = (nb != m_bp[d][ed-1]);
        m_cnt[d][ed] = m_adv[d][ed] ? 5'(nb - m_bp[d][ed-1]) : m_cnt[d][ed-1];
        m_err[d][ed] = (m_adv[d][ed] && ($countones(prev_sg ^ pp) > 1)) ||
                       (m_err[d][ed-1] && !clr);
      end
    end
    if (!rst_n) last_rst = ed;
  endtask

  task automatic compare();
    chk("sg2",  sg2,  m_sg[0][ed]);  chk("bp2",  bp2,  m_bp[0][ed]);
    chk("adv2", adv2, m_adv[0][ed]); chk("cnt2", cnt2, m_cnt[0][ed]);
    chk("err2", err2, m_err[0][ed]);
    chk("sg4",  sg4,  m_sg[1][ed]);  chk("bp4",  bp4,  m_bp[1][ed]);
    chk("adv4", adv4, m_adv[1][ed]); chk("cnt4", cnt4, m_cnt[1][ed]);
    chk("err4", err4, m_err[1][ed]);
  endtask

  // One rising edge: update the model with the sampled inputs, then check on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pulses, r;
    logic [4:0] b;
    for (int d = 0; d < 2; d++) begin
      m_sg[d][0] = '0; m_bp[d][0] = '0; m_cnt[d][0] = '0;
      m_adv[d][0] = 1'b0; m_err[d][0] = 1'b0;
    end
    hin[0] = '0;
    rst_n = 1'b0; g = '0; clr = 1'b0;
    @(negedge clk);
    steps(3);
    chk("rst_sg2", sg2, 0); chk("rst_bp2", bp2, 0); chk("rst_adv2", adv2, 0);
    chk("rst_cnt2", cnt2, 0); chk("rst_err2", err2, 0); chk("rst_sg4", sg4, 0);

    // Latency after reset, both depths.
    rst_n = 1'b1; g = 5'b00001;
    steps(2);
    chk("lat_sg2_e2", sg2, 1); chk("lat_sg4_e2", sg4, 0);
    step();
    chk("lat_bp2_e3", bp2, 1); chk("lat_adv2_e3", adv2, 1); chk("lat_cnt2_e3", cnt2, 1);
    chk("lat_sg4_e3", sg4, 0);
    step();
    chk("lat_sg4_e4", sg4, 1); chk("lat_adv2_e4", adv2, 0); chk("lat_bp4_e4", bp4, 0);
    step();
    chk("lat_bp4_e5", bp4, 1); chk("lat_adv4_e5", adv4, 1);

    // Sweep binary 0..5 from the current pointer of 1: six changes.
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      g = b2g(5'(k));
      for (int c = 0; c < 3; c++) begin step(); pulses += int'(adv2); end
    end
    for (int c = 0; c < 3; c++) begin step(); pulses += int'(adv2); end
    chk("sweep_pulses", pulses, 6); chk("sweep_bp2", bp2, 5);
    chk("sweep_sg2", sg2, 5'b00111); chk("sweep_err2", err2, 0);
    chk("model_bp_pin", m_bp[0][ed], 5);

    // Jump to 31 (multi-bit Gray step), clear, then wrap to 0.
    g = 5'b10000;
    steps(5);
    chk("wrap_bp31", bp2, 31); chk("jump_err2", err2, 1); chk("jump_cnt2", cnt2, 26);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_err2", err2, 0);
    g = 5'b00000;
    steps(3);
    chk("wrap_bp0", bp2, 0); chk("wrap_cnt2", cnt2, 1); chk("wrap_err2", err2, 0);
    steps(2);

    // Illegal two-bit step, delayed clear.
    g = 5'b00011;
    steps(3);
    chk("ill_cnt2", cnt2, 2); chk("ill_err2", err2, 1);
    steps(3);
    clr = 1'b1; step(); clr = 1'b0;
    chk("ill_clr_err2", err2, 0);

    // Set and clear on the same edge: set wins.
    g = 5'b00000;
    steps(5);
    clr = 1'b1; step(); clr = 1'b0;
    step();
    chk("pre_coinc_err2", err2, 0);
    g = 5'b00011;
    steps(2);
    clr = 1'b1; step(); clr = 1'b0;
    chk("coinc_err2", err2, 1); chk("coinc_cnt2", cnt2, 2);
    steps(3);
    clr = 1'b1; step(); clr = 1'b0;

    // Mid-operation reset discards in-flight values.
    g = 5'b00111;
    step();
    rst_n = 1'b0; step();
    chk("mrst_sg2", sg2, 0); chk("mrst_bp2", bp2, 0); chk("mrst_adv2", adv2, 0);
    chk("mrst_cnt2", cnt2, 0); chk("mrst_err2", err2, 0); chk("mrst_sg4", sg4, 0);
    rst_n = 1'b1; step();
    chk("mrst_sg2_r1", sg2, 0);
    step();
    chk("mrst_sg2_r2", sg2, 5'b00111);
    steps(4);

    // Randomised traffic: mostly legal increments, some jumps, clears and resets.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        b = g2b(g) + 5'd1;
        g = b2g(b);
      end else if (r >= 8) begin
        g = 5'($urandom_range(0, 31));
      end
      clr   = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1; clr = 1'b0;
    steps(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
